// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group per stage,
// with the group carry registered forward and a valid/ready handshake on both sides.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int L = WIDTH / GROUP;

    logic             r_valid [L];
    logic [WIDTH-1:0] r_a     [L];
    logic [WIDTH-1:0] r_b     [L];
    logic [WIDTH-1:0] r_sum   [L];
    logic             r_carry [L];
    logic             r_ovf;

    logic             w_adv;
    logic             w_inValid [L];
    logic [WIDTH-1:0] w_inA     [L];
    logic [WIDTH-1:0] w_inB     [L];
    logic [WIDTH-1:0] w_inSum   [L];
    logic             w_inCarry [L];
    logic [WIDTH-1:0] w_nxtSum  [L];
    logic             w_nxtCarry[L];
    logic             w_msbCarryIn;
    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_p;
    logic [GROUP:0]   w_c;
    logic             w_term;

    assign w_adv     = !r_valid[L-1] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_valid[L-1];
    assign sum       = r_sum[L-1];
    assign cout      = r_carry[L-1];
    assign ovf       = r_ovf;

    always_comb begin
        // Bubbles enter with zeroed operands so idle stages never show stale data.
        w_inValid[0] = in_valid;
        w_inA[0]     = in_valid ? a : '0;
        w_inB[0]     = in_valid ? (sub ? ~b : b) : '0;
        w_inCarry[0] = in_valid && (sub || cin);
        w_inSum[0]   = '0;
        for (int i = 1; i < L; i++) begin
            w_inValid[i] = r_valid[i-1];
            w_inA[i]     = r_a[i-1];
            w_inB[i]     = r_b[i-1];
            w_inCarry[i] = r_carry[i-1];
            w_inSum[i]   = r_sum[i-1];
        end

        w_msbCarryIn = 1'b0;
        w_g          = '0;
        w_p          = '0;
        w_c          = '0;
        w_term       = 1'b0;
        for (int i = 0; i < L; i++) begin
            w_g    = w_inA[i][i*GROUP +: GROUP] & w_inB[i][i*GROUP +: GROUP];
            w_p    = w_inA[i][i*GROUP +: GROUP] ^ w_inB[i][i*GROUP +: GROUP];
            w_c    = '0;
            w_c[0] = w_inCarry[i];
            // Each carry is a flat sum of products of g/p and the group carry-in.
            for (int j = 0; j < GROUP; j++) begin
                w_term = w_inCarry[i];
                for (int k = 0; k <= j; k++) begin
                    w_term = w_term & w_p[k];
                end
                w_c[j+1] = w_term;
                for (int k = 0; k <= j; k++) begin
                    w_term = w_g[k];
                    for (int m = k + 1; m <= j; m++) begin
                        w_term = w_term & w_p[m];
                    end
                    w_c[j+1] = w_c[j+1] | w_term;
                end
            end
            w_nxtSum[i]                    = w_inSum[i];
            w_nxtSum[i][i*GROUP +: GROUP]  = w_p ^ w_c[GROUP-1:0];
            w_nxtCarry[i]                  = w_c[GROUP];
            if (i == L - 1) begin
                w_msbCarryIn = w_c[GROUP-1];
            end
        end
    end

    // All stages shift together; a stalled output freezes the whole pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            for (int i = 0; i < L; i++) begin
                r_valid[i] <= 1'b0;
                r_a[i]     <= '0;
                r_b[i]     <= '0;
                r_sum[i]   <= '0;
                r_carry[i] <= 1'b0;
            end
        end else if (w_adv) begin
            r_ovf <= w_msbCarryIn ^ w_nxtCarry[L-1];
            for (int i = 0; i < L; i++) begin
                r_valid[i] <= w_inValid[i];
                r_a[i]     <= w_inA[i];
                r_b[i]     <= w_inB[i];
                r_sum[i]   <= w_nxtSum[i];
                r_carry[i] <= w_nxtCarry[i];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Testbench for pipelined_cla_adder: three configurations (16/4, 8/8, 32/2) driven with
// directed and random traffic, checked against an arithmetic reference model.
module tb_pipelined_cla_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  inValid = '0;
    logic [2:0]  outReady = '0;
    logic [2:0]  cinV = '0;
    logic [2:0]  subV = '0;
    logic [31:0] opA [3];
    logic [31:0] opB [3];
    logic [2:0]  inReady;
    logic [2:0]  outValid;
    logic [2:0]  coutV;
    logic [2:0]  ovfV;
    logic [15:0] sum0;
    logic [7:0]  sum1;
    logic [31:0] sum2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .a(opA[0][15:0]), .b(opB[0][15:0]), .cin(cinV[0]), .sub(subV[0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]), .sum(sum0),
        .cout(coutV[0]), .ovf(ovfV[0])
    );

    pipelined_cla_adder #(.WIDTH(8), .GROUP(8)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .a(opA[1][7:0]), .b(opB[1][7:0]), .cin(cinV[1]), .sub(subV[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]), .sum(sum1),
        .cout(coutV[1]), .ovf(ovfV[1])
    );

    pipelined_cla_adder #(.WIDTH(32), .GROUP(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .a(opA[2]), .b(opB[2]), .cin(cinV[2]), .sub(subV[2]),
        .out_valid(outValid[2]), .out_ready(outReady[2]), .sum(sum2),
        .cout(coutV[2]), .ovf(ovfV[2])
    );

    function automatic int widthOf(input int k);
        return (k == 0) ? 16 : (k == 1) ? 8 : 32;
    endfunction

    function automatic int latencyOf(input int k);
        return (k == 0) ? 4 : (k == 1) ? 1 : 16;
    endfunction

    // Packed as {cout, ovf, sum zero-extended to 32 bits}.
    function automatic logic [33:0] observed(input int k);
        case (k)
            0:       return {coutV[0], ovfV[0], 16'h0, sum0};
            1:       return {coutV[1], ovfV[1], 24'h0, sum1};
            default: return {coutV[2], ovfV[2], sum2};
        endcase
    endfunction

    // Plain unsigned/signed arithmetic; sub mode ignores cin and reports a >= b on cout.
    function automatic logic [33:0] refModel(input int w, input logic [31:0] x,
                                             input logic [31:0] y, input logic c,
                                             input logic s);
        longint unsigned mask, half, ux, uy, full;
        longint          sx, sy, r;
        logic            co, ov;
        logic [31:0]     res;
        mask = (64'd1 << w) - 64'd1;
        half = 64'd1 << (w - 1);
        ux   = {32'h0, x} & mask;
        uy   = {32'h0, y} & mask;
        if (!s) begin
            full = ux + uy + {63'h0, c};
            co   = ((full >> w) & 64'd1) != 64'd0;
            res  = 32'(full & mask);
        end else begin
            co   = ux >= uy;
            res  = 32'((ux - uy) & mask);
        end
        sx = (ux >= half) ? longint'(ux) - longint'(mask + 64'd1) : longint'(ux);
        sy = (uy >= half) ? longint'(uy) - longint'(mask + 64'd1) : longint'(uy);
        r  = s ? (sx - sy) : (sx + sy + longint'({63'h0, c}));
        ov = (r > longint'(half) - 1) || (r < -longint'(half));
        return {co, ov, res};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single operation into an idle pipeline; output must appear exactly L edges later.
    task automatic latencyOp(input int k, input logic [31:0] x, input logic [31:0] y,
                             input logic c, input logic s, input logic [33:0] exp,
                             input string tag);
        int lat;
        lat = latencyOf(k);
        @(negedge clk);
        outReady[k] = 1'b1;
        inValid[k]  = 1'b1;
        opA[k]      = x;
        opB[k]      = y;
        cinV[k]     = c;
        subV[k]     = s;
        #1;
        checkOutput({tag, "_in_ready"}, {63'h0, inReady[k]}, 64'd1);
        @(posedge clk);
        #1;
        inValid[k] = 1'b0;
        opA[k]     = $urandom;
        opB[k]     = $urandom;
        for (int j = 1; j <= lat; j++) begin
            @(negedge clk);
            if (j < lat) begin
                checkOutput({tag, "_early_valid"}, {63'h0, outValid[k]}, 64'd0);
            end else begin
                checkOutput({tag, "_valid"}, {63'h0, outValid[k]}, 64'd1);
                checkOutput({tag, "_result"}, {30'h0, observed(k)}, {30'h0, exp});
            end
        end
    endtask

    // Random stream; mode 0 = always ready, mode 1 = random backpressure with a
    // forced six-cycle stall and random input bubbles.
    task automatic applyStimulus(input int k, input int n, input int mode);
        logic [33:0] expQ [$];
        logic [33:0] obs;
        logic [33:0] prevObs;
        logic        prevStall;
        logic        willTake;
        logic        willAccept;
        int          issued;
        int          received;
        int          iter;
        int          budget;
        issued    = 0;
        received  = 0;
        iter      = 0;
        prevStall = 1'b0;
        prevObs   = '0;
        budget    = n * 8 + latencyOf(k) + 50;
        while ((issued < n || received < n) && iter < budget) begin
            @(negedge clk);
            obs = observed(k);
            if (prevStall) begin
                checkOutput("stall_hold", {29'h0, outValid[k], obs}, {29'h0, 1'b1, prevObs});
            end
            if (mode == 0)
                outReady[k] = 1'b1;
            else
                outReady[k] = (iter >= 4 && iter < 10) ? 1'b0 : 1'($urandom_range(0, 1));
            inValid[k] = (issued < n) && (mode == 0 || $urandom_range(0, 3) != 0);
            opA[k]     = $urandom;
            opB[k]     = $urandom;
            cinV[k]    = 1'($urandom_range(0, 1));
            subV[k]    = 1'($urandom_range(0, 1));
            #1;
            checkOutput("in_ready", {63'h0, inReady[k]}, {63'h0, !(outValid[k] && !outReady[k])});
            willTake   = outValid[k] && outReady[k];
            willAccept = inValid[k] && inReady[k];
            if (willTake) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $error("[TB] FAIL unexpected_out: observed=%0h expected=none", obs);
                end else begin
                    checkOutput("stream_result", {30'h0, obs}, {30'h0, expQ.pop_front()});
                    received++;
                end
            end
            if (willAccept) begin
                expQ.push_back(refModel(widthOf(k), opA[k], opB[k], cinV[k], subV[k]));
                issued++;
            end
            checkOutput("in_flight", {63'h0, expQ.size() <= latencyOf(k)}, 64'd1);
            prevStall = outValid[k] && !outReady[k];
            prevObs   = obs;
            iter++;
        end
        @(posedge clk);
        #1;
        inValid[k]  = 1'b0;
        outReady[k] = 1'b1;
        checkOutput("stream_drained", 64'(received), 64'(n));
        if (mode == 0) begin
            checkOutput("stream_cycles", 64'(iter), 64'(n + latencyOf(k)));
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            opA[k] = '0;
            opB[k] = '0;
        end
        #23;
        for (int k = 0; k < 3; k++) begin
            checkOutput("reset_out_valid", {63'h0, outValid[k]}, 64'd0);
            checkOutput("reset_outputs", {30'h0, observed(k)}, 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_reset_in_ready", {61'h0, inReady}, 64'd7);

        $display("[TB] directed operations, 16-bit / group 4");
        latencyOp(0, 32'h0001, 32'h0002, 1'b0, 1'b0, {1'b0, 1'b0, 32'h0003}, "add_basic");
        latencyOp(0, 32'hFFFF, 32'h0000, 1'b1, 1'b0, {1'b1, 1'b0, 32'h0000}, "carry_chain");
        latencyOp(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h8000}, "add_ovf");
        latencyOp(0, 32'h0005, 32'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFE}, "sub_borrow");
        latencyOp(0, 32'h8000, 32'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF}, "sub_ovf");
        latencyOp(0, 32'h0010, 32'h0003, 1'b1, 1'b1, {1'b1, 1'b0, 32'h000D}, "sub_cin_ignored");

        $display("[TB] random streams, 16-bit / group 4");
        applyStimulus(0, 32, 0);
        applyStimulus(0, 10, 1);

        $display("[TB] reset with operations in flight");
        @(negedge clk);
        outReady[0] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            inValid[0] = 1'b1;
            opA[0]     = $urandom;
            opB[0]     = $urandom;
            @(negedge clk);
        end
        inValid[0] = 1'b0;
        @(negedge clk);
        checkOutput("pre_reset_valid", {63'h0, outValid[0]}, 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_valid", {63'h0, outValid[0]}, 64'd0);
        checkOutput("mid_reset_outputs", {30'h0, observed(0)}, 64'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        outReady[0] = 1'b1;
        #1;
        checkOutput("release_in_ready", {63'h0, inReady[0]}, 64'd1);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            checkOutput("no_stale_result", {63'h0, outValid[0]}, 64'd0);
        end

        $display("[TB] 8-bit / group 8 (single stage)");
        latencyOp(1, 32'h00FF, 32'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h0000}, "l1_add");
        latencyOp(1, 32'h0080, 32'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h007F}, "l1_sub");
        applyStimulus(1, 12, 1);
        applyStimulus(1, 8, 0);

        $display("[TB] 32-bit / group 2 (sixteen stages)");
        latencyOp(2, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h00000000}, "l16_add");
        latencyOp(2, 32'h00000003, 32'h00000004, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFFFFFF}, "l16_sub");
        applyStimulus(2, 10, 1);
        applyStimulus(2, 20, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
